// File: rtl/writeback_stage_pkg.sv
// Shared widths, source-select encoding and condition-code helper for the
// LC-3 writeback stage and anything that predicts its behaviour.
package writeback_stage_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2,
        WB_NPC = 2'd3
    } wb_src_t;

    localparam int PSR_N = 2;
    localparam int PSR_Z = 1;
    localparam int PSR_P = 0;

    // Exactly one of N/Z/P is set for any value written back.
    function automatic logic [2:0] calc_psr(input logic [DATA_W-1:0] value);
        logic [2:0] cc;
        cc = '0;
        if (value[DATA_W-1]) begin
            cc[PSR_N] = 1'b1;
        end else if (value == '0) begin
            cc[PSR_Z] = 1'b1;
        end else begin
            cc[PSR_P] = 1'b1;
        end
        return cc;
    endfunction

endpackage

// File: rtl/writeback_regfile.sv
// General register file: one write port, two registered read ports that see
// a same-cycle write (write-first), synchronous active-high reset.
module writeback_regfile
    import writeback_stage_pkg::*;
#(
    parameter int NREGS = NUM_REGS,
    parameter int W     = DATA_W,
    parameter int IW    = REG_IDX_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we_i,
    input  logic [IW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [IW-1:0] raddr1_i,
    input  logic [IW-1:0] raddr2_i,
    output logic [W-1:0]  rdata1_o,
    output logic [W-1:0]  rdata2_o
);

    logic [W-1:0] rf_q [NREGS];
    logic [W-1:0] rdata1_q, rdata1_d;
    logic [W-1:0] rdata2_q, rdata2_d;

    // A write landing on the register being read must be visible at once,
    // otherwise the consumer would see the stale value for a cycle.
    always_comb begin
        rdata1_d = rf_q[raddr1_i];
        rdata2_d = rf_q[raddr2_i];
        if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_d = wdata_i;
        end
        if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_d = wdata_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            if (we_i) begin
                rf_q[waddr_i] <= wdata_i;
            end
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    assign rdata1_o = rdata1_q;
    assign rdata2_o = rdata2_q;

endmodule

// File: rtl/writeback_stage.sv
// LC-3 writeback stage: picks the retiring result, writes the register file
// and updates the N/Z/P condition codes.
module writeback_stage
    import writeback_stage_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable_writeback,
    input  logic [1:0]           W_Control,
    input  logic [DATA_W-1:0]    aluout,
    input  logic [DATA_W-1:0]    memout,
    input  logic [DATA_W-1:0]    pcout,
    input  logic [DATA_W-1:0]    npc,
    input  logic [REG_IDX_W-1:0] dr,
    input  logic [REG_IDX_W-1:0] sr1,
    input  logic [REG_IDX_W-1:0] sr2,
    output logic [DATA_W-1:0]    VSR1,
    output logic [DATA_W-1:0]    VSR2,
    output logic [2:0]           psr
);

    logic [DATA_W-1:0] dr_in;
    logic [2:0]        psr_q, psr_d;

    always_comb begin
        dr_in = aluout;
        case (wb_src_t'(W_Control))
            WB_ALU: dr_in = aluout;
            WB_MEM: dr_in = memout;
            WB_PC:  dr_in = pcout;
            WB_NPC: dr_in = npc;
        endcase
    end

    // Condition codes only move with a real write; 000 marks "nothing written yet".
    always_comb begin
        psr_d = psr_q;
        if (enable_writeback) begin
            psr_d = calc_psr(dr_in);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            psr_q <= '0;
        end else begin
            psr_q <= psr_d;
        end
    end

    writeback_regfile u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we_i     (enable_writeback),
        .waddr_i  (dr),
        .wdata_i  (dr_in),
        .raddr1_i (sr1),
        .raddr2_i (sr2),
        .rdata1_o (VSR1),
        .rdata2_o (VSR2)
    );

    assign psr = psr_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed vector table plus a
// randomized phase checked against an independent behavioural model.
module tb_writeback_stage;

    logic        clock;
    logic        reset;
    logic        enable_writeback;
    logic [1:0]  W_Control;
    logic [15:0] aluout, memout, pcout, npc;
    logic [2:0]  dr, sr1, sr2;
    logic [15:0] VSR1, VSR2;
    logic [2:0]  psr;

    writeback_stage dut (
        .clock            (clock),
        .reset            (reset),
        .enable_writeback (enable_writeback),
        .W_Control        (W_Control),
        .aluout           (aluout),
        .memout           (memout),
        .pcout            (pcout),
        .npc              (npc),
        .dr               (dr),
        .sr1              (sr1),
        .sr2              (sr2),
        .VSR1             (VSR1),
        .VSR2             (VSR2),
        .psr              (psr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        en;
        logic [1:0]  wctl;
        logic [15:0] alu, mem, pc, np;
        logic [2:0]  d, s1, s2;
        logic [15:0] e1, e2;
        logic [2:0]  ep;
        string       name;
    } vec_t;

    typedef struct {
        logic [15:0] e1, e2;
        logic [2:0]  ep;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   nChecks = 0;
    int   nFails  = 0;

    // Independent reference state for the random phase
    logic [15:0] mRf [8];
    logic [15:0] mV1, mV2;
    logic [2:0]  mPsr;

    function automatic vec_t mk(input logic rst, input logic en, input logic [1:0] wctl,
                                input logic [15:0] alu, input logic [15:0] mem,
                                input logic [15:0] pc, input logic [15:0] np,
                                input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                                input logic [15:0] e1, input logic [15:0] e2,
                                input logic [2:0] ep, input string name);
        vec_t v;
        v.rst = rst; v.en = en; v.wctl = wctl;
        v.alu = alu; v.mem = mem; v.pc = pc; v.np = np;
        v.d = d; v.s1 = s1; v.s2 = s2;
        v.e1 = e1; v.e2 = e2; v.ep = ep; v.name = name;
        return v;
    endfunction

    // Drive one cycle of inputs on the falling edge and queue what must appear after the next rising edge.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        @(negedge clock);
        reset            = v.rst;
        enable_writeback = v.en;
        W_Control        = v.wctl;
        aluout           = v.alu;
        memout           = v.mem;
        pcout            = v.pc;
        npc              = v.np;
        dr               = v.d;
        sr1              = v.s1;
        sr2              = v.s2;
        e.e1 = v.e1; e.e2 = v.e2; e.ep = v.ep; e.name = v.name;
        sb.push_back(e);
    endtask

    task automatic checkOne(input string name, input string field,
                            input logic [15:0] act, input logic [15:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, act, req);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            checkOne(e.name, "VSR1", VSR1, e.e1);
            checkOne(e.name, "VSR2", VSR2, e.e2);
            checkOne(e.name, "psr", {13'd0, psr}, {13'd0, e.ep});
        end
    endtask

    function automatic logic [2:0] modelPsr(input logic [15:0] v);
        if (v[15])          return 3'b100;
        else if (v == 16'h0) return 3'b010;
        else                return 3'b001;
    endfunction

    // Advance the reference model by one rising edge for the given inputs.
    function automatic vec_t modelStep(input vec_t v);
        vec_t r;
        logic [15:0] din;
        r = v;
        case (v.wctl)
            2'd0: din = v.alu;
            2'd1: din = v.mem;
            2'd2: din = v.pc;
            default: din = v.np;
        endcase
        if (v.rst) begin
            for (int i = 0; i < 8; i++) mRf[i] = 16'h0;
            mV1 = 16'h0; mV2 = 16'h0; mPsr = 3'b000;
        end else begin
            mV1 = (v.en && v.d == v.s1) ? din : mRf[v.s1];
            mV2 = (v.en && v.d == v.s2) ? din : mRf[v.s2];
            if (v.en) begin
                mRf[v.d] = din;
                mPsr = modelPsr(din);
            end
        end
        r.e1 = mV1; r.e2 = mV2; r.ep = mPsr;
        return r;
    endfunction

    initial begin
        vec_t v;
        reset = 1'b1; enable_writeback = 1'b0; W_Control = 2'd0;
        aluout = '0; memout = '0; pcout = '0; npc = '0;
        dr = '0; sr1 = '0; sr2 = '0;

        //          rst  en  wctl  alu       mem       pc        npc       dr  s1  s2  e1        e2        psr
        vecs.push_back(mk(1, 0, 2'd0, 16'h1234, 16'h0,    16'h0,    16'h0,    0, 3, 5, 16'h0,    16'h0,    3'b000, "reset1"));
        vecs.push_back(mk(1, 0, 2'd0, 16'h1234, 16'h0,    16'h0,    16'h0,    0, 3, 5, 16'h0,    16'h0,    3'b000, "reset2"));
        vecs.push_back(mk(0, 0, 2'd0, 16'hFFFF, 16'h0,    16'h0,    16'h0,    3, 3, 5, 16'h0,    16'h0,    3'b000, "idle1"));
        vecs.push_back(mk(0, 0, 2'd1, 16'h0,    16'h7777, 16'h0,    16'h0,    5, 3, 5, 16'h0,    16'h0,    3'b000, "idle2"));
        vecs.push_back(mk(0, 1, 2'd0, 16'h8001, 16'h4444, 16'h5555, 16'h6666, 2, 0, 0, 16'h0,    16'h0,    3'b100, "wrAluNeg"));
        vecs.push_back(mk(0, 1, 2'd1, 16'h1234, 16'h0,    16'h5555, 16'h6666, 3, 0, 0, 16'h0,    16'h0,    3'b010, "wrMemZero"));
        vecs.push_back(mk(0, 1, 2'd3, 16'h5555, 16'h6666, 16'h7777, 16'h3001, 4, 0, 0, 16'h0,    16'h0,    3'b001, "wrNpcPos"));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0,    0, 2, 4, 16'h8001, 16'h3001, 3'b001, "readR2R4"));
        vecs.push_back(mk(0, 1, 2'd0, 16'h1111, 16'h0,    16'h0,    16'h0,    6, 0, 0, 16'h0,    16'h0,    3'b001, "wrR6"));
        vecs.push_back(mk(0, 1, 2'd2, 16'h1111, 16'h3333, 16'h2222, 16'h4444, 6, 6, 6, 16'h2222, 16'h2222, 3'b001, "bypassPc"));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0,    0, 6, 3, 16'h2222, 16'h0,    3'b001, "readR6R3"));
        vecs.push_back(mk(0, 0, 2'd0, 16'hFFFF, 16'h0,    16'h0,    16'h0,    1, 1, 2, 16'h0,    16'h8001, 3'b001, "wrDisabled"));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0,    0, 1, 1, 16'h0,    16'h0,    3'b001, "holdR1"));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0005, 16'h0,    16'h0,    16'h0,    7, 7, 0, 16'h0005, 16'h0,    3'b001, "b2bFirst"));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0000, 16'h0,    16'h0,    16'h0,    7, 2, 7, 16'h8001, 16'h0,    3'b010, "b2bSecond"));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0,    0, 7, 6, 16'h0,    16'h2222, 3'b010, "readR7"));
        vecs.push_back(mk(0, 1, 2'd1, 16'h0,    16'h7FFF, 16'h0,    16'h0,    0, 1, 2, 16'h0,    16'h8001, 3'b001, "wrR0"));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0,    0, 0, 0, 16'h7FFF, 16'h7FFF, 3'b001, "readR0"));
        vecs.push_back(mk(1, 1, 2'd0, 16'hABCD, 16'h0,    16'h0,    16'h0,    1, 1, 0, 16'h0,    16'h0,    3'b000, "resetWins"));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0,    0, 1, 2, 16'h0,    16'h0,    3'b000, "postRstR1"));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0,    16'h0,    16'h0,    16'h0,    0, 0, 6, 16'h0,    16'h0,    3'b000, "postRstR0"));

        $display("[TB] directed vectors: %0d", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        // Random phase: start from a known reset, then let the model predict.
        v = mk(1, 0, 2'd0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 3'b000, "rndReset");
        v = modelStep(v);
        applyStimulus(v);
        checkOutput();
        for (int n = 0; n < 80; n++) begin
            v.rst  = ($urandom_range(0, 24) == 0);
            v.en   = ($urandom_range(0, 3) != 0);
            v.wctl = 2'($urandom_range(0, 3));
            v.alu  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            v.mem  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            v.pc   = 16'($urandom);
            v.np   = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
            v.d    = 3'($urandom_range(0, 7));
            v.s1   = 3'($urandom_range(0, 7));
            v.s2   = ($urandom_range(0, 3) == 0) ? v.d : 3'($urandom_range(0, 7));
            v.name = $sformatf("rnd%0d", n);
            v = modelStep(v);
            applyStimulus(v);
            checkOutput();
        end

        nChecks++;
        if (sb.size() != 0) begin
            nFails++;
            $display("[TB] FAIL scoreboardDrain: got %0d entries left, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
